// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin sequencer for a wired-OR bus (IDLE -> DRIVE -> LOAD).
// Define BUS_ARB_CHECK_EN to build the sticky bus/request checker behind err.
module bus_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_DST    = 4,
  parameter int word_width = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*NUM_DST-1:0] dst_mask,
  input  logic [word_width-1:0]      bus_in,
  output logic [NUM_SRC-1:0]         gnt,
  output logic [NUM_DST-1:0]         ld,
  output logic [NUM_SRC-1:0]         done,
  output logic                       busy,
  output logic                       err
);
  localparam int IW = $clog2(NUM_SRC);
  localparam logic [NUM_SRC-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d, pick;
  logic [NUM_DST-1:0] mask_q, mask_d;
  logic               arb;
  // rr_q doubles as the current winner: the pointer always moves to the grantee
  always_comb begin
    int idx;
    logic found;
    idx = 0;
    found = 1'b0;
    pick = rr_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_q) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        pick = IW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    arb = (state_q == IDLE) && (|req);
    state_d = state_q == IDLE ? (arb ? DRIVE : IDLE) : state_q == DRIVE ? LOAD : IDLE;
    rr_d = arb ? pick : rr_q;
    mask_d = arb ? dst_mask[pick*NUM_DST +: NUM_DST] : mask_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= IW'(NUM_SRC - 1);
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
    end
  end
  assign busy = state_q != IDLE;
  assign gnt  = busy ? ONE << rr_q : '0;
  assign done = state_q == LOAD ? gnt : '0;
  assign ld   = state_q == LOAD ? mask_q : '0;
`ifdef BUS_ARB_CHECK_EN
  logic               err_q, err_d;
  logic [NUM_SRC-1:0] req_q;
  always_comb err_d = err_q | (state_q == IDLE ? |bus_in : |(req & ~req_q & gnt));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      req_q <= '0;
    end else begin
      err_q <= err_d;
      req_q <= req;
    end
  end
  assign err = err_q;
`else
  logic unused_bus;
  assign unused_bus = ^bus_in;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter (4 sources, 4 destinations).
module tb_bus_arbiter;
  logic        clk, rst_n;
  logic [3:0]  req, gnt, ld, done;
  logic [15:0] dst_mask;
  logic [31:0] bus_in;
  logic        busy, err;
  typedef struct packed {logic [3:0] g, l, d; logic b, e;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic ee = 1'b0;
`ifdef BUS_ARB_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  bus_arbiter #(.NUM_SRC(4), .NUM_DST(4), .word_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dst_mask(dst_mask), .bus_in(bus_in),
    .gnt(gnt), .ld(ld), .done(done), .busy(busy), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input string f, input logic [3:0] o, input logic [3:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, o, e);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] l,
                      input logic [3:0] d, input logic b);
    exp_t x;
    q.push_back({g, l, d, b, ee});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      x = q.pop_front();
      chk(tag, "gnt", gnt, x.g);
      chk(tag, "ld", ld, x.l);
      chk(tag, "done", done, x.d);
      chk(tag, "busy", {3'b0, busy}, {3'b0, x.b});
      chk(tag, "err", {3'b0, err}, {3'b0, x.e});
    end
  endtask
  initial begin
    rst_n = 1'b0; req = '0; dst_mask = '0; bus_in = '0;
    step("reset", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1; req = 4'b0001; dst_mask = 16'h0006;
    step("single_drive", 4'b0001, 4'h0, 4'h0, 1'b1);
    step("single_load", 4'b0001, 4'b0110, 4'b0001, 1'b1);
    req = '0;
    step("single_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    step("reset2", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1; req = 4'b1111; dst_mask = 16'h8421;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] w;
      w = 4'b0001 << (k % 4);
      step($sformatf("rr%0d_drive", k), w, 4'h0, 4'h0, 1'b1);
      step($sformatf("rr%0d_load", k), w, w, w, 1'b1);
      if (k == 4) req = '0;
      step($sformatf("rr%0d_idle", k), 4'h0, 4'h0, 4'h0, 1'b0);
    end
    req = 4'b0100; dst_mask = 16'h0000;
    step("zmask_drive", 4'b0100, 4'h0, 4'h0, 1'b1);
    step("zmask_load", 4'b0100, 4'h0, 4'b0100, 1'b1);
    req = '0;
    step("zmask_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    req = 4'b0010; dst_mask = 16'h00F0;
    step("abort_drive", 4'b0010, 4'h0, 4'h0, 1'b1);
    rst_n = 1'b0; req = '0;
    step("abort_reset", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1; req = 4'b0011;
    step("post_rst_drive", 4'b0001, 4'h0, 4'h0, 1'b1);
    step("post_rst_load", 4'b0001, 4'h0, 4'b0001, 1'b1);
    req = '0;
    step("post_rst_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    req = 4'b1000; dst_mask = 16'h1000;
    step("mchg_drive", 4'b1000, 4'h0, 4'h0, 1'b1);
    dst_mask = 16'h8000;
    step("mchg_load", 4'b1000, 4'b0001, 4'b1000, 1'b1);
    req = '0;
    step("mchg_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    bus_in = 32'h0000_0010; ee = CHK;
    step("err_set", 4'h0, 4'h0, 4'h0, 1'b0);
    bus_in = '0; req = 4'b0001; dst_mask = 16'h0003;
    step("err_hold_drive", 4'b0001, 4'h0, 4'h0, 1'b1);
    step("err_hold_load", 4'b0001, 4'b0011, 4'b0001, 1'b1);
    req = '0;
    step("err_hold_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b0; ee = 1'b0;
    step("err_clear", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    step("final_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
